// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 constants, FSM state type and LFSR step function
// Purpose: defaults for WIDTH/SEED/TAPS, checker FSM states, and crc_step()
//          which is common to the serial CRC-8 generator and checker.
package crc_pkg;

    localparam int                WIDTH = 8;
    localparam logic [WIDTH-1:0]  SEED  = 8'hD8;
    localparam logic [WIDTH-1:0]  TAPS  = 8'hC4;
    localparam int                LEN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    // Right-shifting Galois step: the bit leaving at lfsr[0] is combined with
    // the incoming serial bit and, when set, folds the tap mask back in.
    function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] lfsr,
                                                  input logic             din,
                                                  input logic [WIDTH-1:0] taps);
        logic fb;
        fb = lfsr[0] ^ din;
        return (lfsr >> 1) ^ (fb ? taps : '0);
    endfunction

endpackage

// File: rtl/crc_checker_if.sv
// rtl/crc_checker_if.sv - serial CRC link bundle between deserialiser and checker
// Purpose: groups the serial input qualifiers and the per-frame result outputs.
// Signals: Data, Active, Crc_Valid (towards checker);
//          Done, Crc_Ok, Crc_Err, Abort, Len (from checker).
// Modports: master = line side / consumer of results, slave = checker.
interface crc_checker_if #(
    parameter int LEN_W = 16
);
    logic             Data;
    logic             Active;
    logic             Crc_Valid;
    logic             Done;
    logic             Crc_Ok;
    logic             Crc_Err;
    logic             Abort;
    logic [LEN_W-1:0] Len;

    modport master (
        output Data, Active, Crc_Valid,
        input  Done, Crc_Ok, Crc_Err, Abort, Len
    );

    modport slave (
        input  Data, Active, Crc_Valid,
        output Done, Crc_Ok, Crc_Err, Abort, Len
    );
endinterface

// File: rtl/crc_lfsr.sv
// rtl/crc_lfsr.sv - CRC LFSR register with seed-load, step and freeze
// Purpose: holds the running CRC remainder; reusable by the generator.
// Ports: clk_i, rst_i (sync, active-high, loads SEED),
//        start_i (lfsr <= step(SEED, data_i)), step_i (lfsr <= step(lfsr, data_i)),
//        data_i (serial bit), lfsr_o (current register value). Neither -> frozen.
module crc_lfsr #(
    parameter int                WIDTH = crc_pkg::WIDTH,
    parameter logic [WIDTH-1:0]  SEED  = crc_pkg::SEED,
    parameter logic [WIDTH-1:0]  TAPS  = crc_pkg::TAPS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             data_i,
    output logic [WIDTH-1:0] lfsr_o
);
    import crc_pkg::*;

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (start_i) begin
            lfsr_d = crc_step(SEED, data_i, TAPS);
        end else if (step_i) begin
            lfsr_d = crc_step(lfsr_q, data_i, TAPS);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/crc_checker.sv
// rtl/crc_checker.sv - serial CRC-8 receiver/checker, one pass/fail per frame
// Purpose: recomputes CRC over payload bits (Active), then compares the
//          trailing CRC bits (Crc_Valid, LSB first) and reports the result.
// Ports: CLK, RST (sync, active-high); bus (crc_checker_if.slave):
//        Data/Active/Crc_Valid in; Done/Crc_Ok/Crc_Err/Abort/Len out.
// Option: CRC_CHECK_STATS_EN adds Frame_Cnt and Err_Cnt (16-bit, saturating).
module crc_checker #(
    parameter int                WIDTH = crc_pkg::WIDTH,
    parameter logic [WIDTH-1:0]  SEED  = crc_pkg::SEED,
    parameter logic [WIDTH-1:0]  TAPS  = crc_pkg::TAPS,
    parameter int                LEN_W = crc_pkg::LEN_W
) (
    input  logic         CLK,
    input  logic         RST,
    crc_checker_if.slave bus
`ifdef CRC_CHECK_STATS_EN
    ,
    output logic [15:0]  Frame_Cnt,
    output logic [15:0]  Err_Cnt
`endif
);
    import crc_pkg::*;

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              mism_q, mism_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic              lfsr_start;
    logic              lfsr_step;
    logic [WIDTH-1:0]  lfsr_q;

    // Compare path: the index/mismatch used for the bit being checked this
    // cycle. On the DATA->CHECK cycle they start from zero, not from the regs.
    logic              chk_en;
    logic [IDX_W-1:0]  chk_idx;
    logic              chk_mism;
    logic              chk_next;

    crc_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (lfsr_start),
        .step_i  (lfsr_step),
        .data_i  (bus.Data),
        .lfsr_o  (lfsr_q)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mism_d     = mism_q;
        ok_d       = ok_q;
        err_d      = err_q;
        len_d      = len_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        lfsr_start = 1'b0;
        lfsr_step  = 1'b0;
        chk_en     = 1'b0;
        chk_idx    = idx_q;
        chk_mism   = mism_q;

        unique case (state_q)
            ST_IDLE, ST_RESULT: begin
                lfsr_start = bus.Active;
            end
            ST_DATA: begin
                if (bus.Active) begin
                    lfsr_step = 1'b1;
                    if (len_q != '1) begin
                        len_d = len_q + 1'b1;
                    end
                end else begin
                    state_d  = ST_CHECK;
                    idx_d    = '0;
                    mism_d   = 1'b0;
                    chk_idx  = '0;
                    chk_mism = 1'b0;
                    chk_en   = bus.Crc_Valid;
                end
            end
            ST_CHECK: begin
                // Active has priority over Crc_Valid: a new frame preempts the check.
                if (bus.Active) begin
                    abort_d    = 1'b1;
                    lfsr_start = 1'b1;
                end else begin
                    chk_en = bus.Crc_Valid;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        chk_next = chk_mism | (bus.Data ^ lfsr_q[chk_idx]);

        if (chk_en) begin
            mism_d = chk_next;
            if (chk_idx == LAST_IDX) begin
                done_d  = 1'b1;
                ok_d    = ~chk_next;
                err_d   = chk_next;
                state_d = ST_RESULT;
                idx_d   = '0;
            end else begin
                idx_d = chk_idx + 1'b1;
            end
        end

        if (lfsr_start) begin
            state_d = ST_DATA;
            len_d   = LEN_W'(1);
            ok_d    = 1'b0;
            err_d   = 1'b0;
            idx_d   = '0;
            mism_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mism_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mism_q  <= mism_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            len_q   <= len_d;
        end
    end

    assign bus.Done    = done_q;
    assign bus.Crc_Ok  = ok_q;
    assign bus.Crc_Err = err_q;
    assign bus.Abort   = abort_q;
    assign bus.Len     = len_q;

`ifdef CRC_CHECK_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (done_d && frame_cnt_q != 16'hFFFF) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (done_d && err_d && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign Frame_Cnt = frame_cnt_q;
    assign Err_Cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_checker.sv
// tb/tb_crc_checker.sv - self-checking bench for crc_checker against a CRC reference model
module tb_crc_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc_checker_if #(.LEN_W(16)) bus ();

`ifdef CRC_CHECK_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
`endif

    crc_checker dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
`ifdef CRC_CHECK_STATS_EN
        ,
        .Frame_Cnt (frame_cnt),
        .Err_Cnt   (err_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int m_frames = 0;
    int m_bad = 0;
    logic payload[$];

    always @(negedge clk) begin
        if (bus.Done)  done_cnt++;
        if (bus.Abort) abort_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC remainder of the payload: start from the seed, shift each bit in,
    // folding polynomial 0xC4 back whenever the outgoing bit differs from the data.
    function automatic logic [7:0] ref_crc();
        logic [7:0] r;
        r = 8'hD8;
        foreach (payload[i]) begin
            if (r[0] != payload[i]) r = (r >> 1) ^ 8'hC4;
            else                    r = r >> 1;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.Active    = 1'b0;
        bus.Crc_Valid = 1'($urandom_range(0, 1));
        bus.Data      = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_gap();
        bus.Active    = 1'b0;
        bus.Crc_Valid = 1'b0;
        bus.Data      = 1'($urandom_range(0, 1));
    endtask

    // Drives payload (skipping bits already sent) then crc_tx LSB first with
    // 'gaps' idle cycles in front of the first CRC bits, then checks the result.
    task automatic run_frame(input string tag, input logic [7:0] crc_tx,
                             input int gaps, input int skip);
        int   pre;
        int   exp_len;
        logic exp_ok;
        exp_ok  = (crc_tx == ref_crc());
        exp_len = (payload.size() > 65535) ? 65535 : payload.size();
        pre     = done_cnt;
        for (int i = skip; i < payload.size(); i++) begin
            bus.Active    = 1'b1;
            bus.Crc_Valid = 1'($urandom_range(0, 1));
            bus.Data      = payload[i];
            tick();
        end
        for (int b = 0; b < 8; b++) begin
            if (b < gaps) begin
                drive_gap();
                tick();
            end
            bus.Active    = 1'b0;
            bus.Crc_Valid = 1'b1;
            bus.Data      = crc_tx[b];
            tick();
        end
        check({tag, "_done"}, 32'(bus.Done), 32'd1);
        check({tag, "_ok"},   32'(bus.Crc_Ok), 32'(exp_ok));
        check({tag, "_err"},  32'(bus.Crc_Err), 32'(!exp_ok));
        check({tag, "_len"},  32'(bus.Len), 32'(exp_len));
        drive_idle();
        tick();
        check({tag, "_done_once"}, 32'(done_cnt - pre), 32'd1);
        check({tag, "_hold"}, {30'd0, bus.Done, bus.Crc_Ok}, {31'd0, exp_ok});
        m_frames++;
        if (!exp_ok) m_bad++;
    endtask

    task automatic rand_payload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(1'($urandom_range(0, 1)));
    endtask

    initial begin
        logic [7:0] c;
        logic [7:0] a5;
        int         ab0;
        int         d0;

        rst = 1'b1;
        drive_idle();
        repeat (3) tick();
        check("rst_done",  32'(bus.Done), 32'd0);
        check("rst_ok",    32'(bus.Crc_Ok), 32'd0);
        check("rst_err",   32'(bus.Crc_Err), 32'd0);
        check("rst_abort", 32'(bus.Abort), 32'd0);
        check("rst_len",   32'(bus.Len), 32'd0);
`ifdef CRC_CHECK_STATS_EN
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
`endif
        rst = 1'b0;
        tick();

        payload = {1'b0};
        run_frame("p0_6c", 8'h6C, 0, 0);
        payload = {1'b1};
        run_frame("p1_a8", 8'hA8, 0, 0);
        run_frame("p1_a8_flip3", 8'hA8 ^ 8'h08, 0, 0);

        a5 = 8'hA5;
        payload.delete();
        for (int i = 7; i >= 0; i--) payload.push_back(a5[i]);
        run_frame("a5_gaps", ref_crc(), 3, 0);

        // Restart during the CRC phase.
        ab0 = abort_cnt;
        d0  = done_cnt;
        rand_payload(6);
        c = ref_crc();
        foreach (payload[i]) begin
            bus.Active = 1'b1; bus.Crc_Valid = 1'b0; bus.Data = payload[i];
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            bus.Active = 1'b0; bus.Crc_Valid = 1'b1; bus.Data = c[b];
            tick();
        end
        bus.Active = 1'b1; bus.Crc_Valid = 1'b1; bus.Data = 1'b1;
        tick();
        check("abort_pulse", 32'(bus.Abort), 32'd1);
        check("abort_nodone", 32'(bus.Done), 32'd0);
        check("abort_len", 32'(bus.Len), 32'd1);
        payload = {1'b1};
        run_frame("abort_restart", 8'hA8, 0, 1);
        check("abort_count", 32'(abort_cnt - ab0), 32'd1);
        check("abort_done_count", 32'(done_cnt - d0), 32'd1);

        for (int k = 0; k < 20; k++) begin
            rand_payload($urandom_range(1, 40));
            c = ref_crc();
            if ($urandom_range(0, 2) == 0) c = c ^ (8'h01 << $urandom_range(0, 7));
            run_frame($sformatf("rand%0d", k), c, $urandom_range(0, 5), 0);
        end

        // Reset in the middle of the CRC phase.
        ab0 = abort_cnt;
        d0  = done_cnt;
        rand_payload(5);
        c = ref_crc();
        foreach (payload[i]) begin
            bus.Active = 1'b1; bus.Crc_Valid = 1'b0; bus.Data = payload[i];
            tick();
        end
        for (int b = 0; b < 3; b++) begin
            bus.Active = 1'b0; bus.Crc_Valid = 1'b1; bus.Data = c[b];
            tick();
        end
        rst = 1'b1;
        tick();
        check("mrst_outs", {27'd0, bus.Done, bus.Crc_Ok, bus.Crc_Err, bus.Abort, 1'b0}, 32'd0);
        check("mrst_len", 32'(bus.Len), 32'd0);
        rst = 1'b0;
        m_frames = 0;
        m_bad    = 0;
        drive_idle();
        repeat (2) tick();
        check("mrst_no_pulse", 32'(done_cnt - d0 + abort_cnt - ab0), 32'd0);

        for (int k = 0; k < 3; k++) begin
            rand_payload($urandom_range(1, 12));
            c = ref_crc();
            if (k == 1) c = c ^ 8'h10;
            run_frame($sformatf("stat%0d", k), c, k, 0);
        end
`ifdef CRC_CHECK_STATS_EN
        check("stats_frames", 32'(frame_cnt), 32'(m_frames));
        check("stats_errs",   32'(err_cnt), 32'(m_bad));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
